// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and sequencing controller for a 5-stage RV32 pipeline.
//   - EX-stage operand forwarding selects (MEM result has priority over WB).
//   - Load-use stall of Fetch/Decode with a bubble injected into Execute.
//   - Branch/jump flush of Decode and Execute.
//   - Multi-cycle EX sequencing (iterative MUL/DIV): one start pulse, then
//     holds the front of the pipe until done, or until a timeout fires.
//   - Saturating performance counters of StallD and FlushD cycles.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   Rs1D, Rs2D            source registers of the instruction in Decode
//   Rs1E, Rs2E, RdE       source/dest registers of the instruction in Execute
//   LoadE                 Execute instruction is a load
//   RdM, RegWriteM        Memory-stage destination and write enable
//   RdW, RegWriteW        Writeback-stage destination and write enable
//   PCSrcE                branch taken / jump resolved in Execute
//   mc_reqE               Execute instruction needs the multi-cycle unit
//   mc_done               multi-cycle result valid (one-cycle pulse)
//   ForwardAE, ForwardBE  00 regfile, 01 ResultW, 10 ALUResultM
//   StallF/D/E            hold PC, IF/ID, ID/EX registers
//   FlushD/E/M            clear IF/ID, ID/EX, EX/MEM registers next edge
//   mc_start              one-cycle start pulse to the multi-cycle unit
//   mc_err                sticky multi-cycle timeout flag
//   stall_cnt, flush_cnt  saturating counts of StallD / FlushD cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             LoadE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             mc_reqE,
  input  logic             mc_done,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             mc_start,
  output logic             mc_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, MC_WAIT} state_t;

  localparam int            TW         = $clog2(MC_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(MC_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             mc_err_q, mc_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Ungated control decisions; outputs are these ANDed with rst.
  logic [1:0] fwd_a, fwd_b;
  logic       stall_f, stall_d, stall_e;
  logic       flush_d, flush_e, flush_m;
  logic       start;
  logic       load_use;

  // Forwarding select for one EX source operand. x0 is never forwarded
  // because a write to x0 is architecturally discarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       wm, input logic [4:0] rdm,
                                         input logic       ww, input logic [4:0] rdw);
    if (wm && (rdm != 5'd0) && (rdm == rs))
      return 2'b10;
    else if (ww && (rdw != 5'd0) && (rdw == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    fwd_b = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
  end

  assign load_use = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    mc_err_d = mc_err_q;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    start    = 1'b0;

    case (state_q)
      RUN: begin
        if (PCSrcE) begin
          // Redirect wins over everything: the wrong-path Decode/Execute
          // instructions are squashed, so neither a stall nor a start applies.
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (mc_reqE) begin
          // Launch the multi-cycle op; EX holds its operands while a bubble
          // goes into MEM each waiting cycle.
          start   = 1'b1;
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          state_d = MC_WAIT;
          timer_d = '0;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end

      MC_WAIT: begin
        if (mc_done) begin
          // Result is ready: release the pipe so the EX result advances.
          state_d = RUN;
        end else if (timer_q == TIMER_LAST) begin
          // Give up on the unit; release the pipe and flag the error.
          mc_err_d = 1'b1;
          state_d  = RUN;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          timer_d = timer_q + TW'(1);
        end
      end
    endcase
  end

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_d && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_d && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      timer_q     <= '0;
      mc_err_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mc_err_q    <= mc_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Combinational outputs are forced low while reset is asserted so the
  // pipeline sees a quiet controller regardless of the input values.
  assign ForwardAE = rst ? fwd_a : 2'b00;
  assign ForwardBE = rst ? fwd_b : 2'b00;
  assign StallF    = rst & stall_f;
  assign StallD    = rst & stall_d;
  assign StallE    = rst & stall_e;
  assign FlushD    = rst & flush_d;
  assign FlushE    = rst & flush_e;
  assign FlushM    = rst & flush_m;
  assign mc_start  = rst & start;
  assign mc_err    = mc_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
